// File: rtl/free_list_allocator_32_pkg.sv
// mips_core_pkg: shared pool sizing types and reset-count helper for the core's free lists
package mips_core_pkg;
  localparam int FREE_LIST_DEPTH = 32;
  typedef logic [4:0] pool_idx_t;
  typedef logic [5:0] pool_cnt_t;
  function automatic pool_cnt_t free_slots(input logic [31:0] mask);
    pool_cnt_t n;
    n = 6'(FREE_LIST_DEPTH);
    for (int i = 0; i < FREE_LIST_DEPTH; i++) n = n - {5'd0, mask[i]};
    return n;
  endfunction
endpackage

// File: rtl/free_list_allocator_32_prio.sv
// priority_encoder_32: index of the lowest (or highest) input equal to SIGNAL, 0 when none match
module priority_encoder_32
  import mips_core_pkg::*;
#(
  parameter bit HIGH_PRIORITY = 1'b0,
  parameter bit SIGNAL        = 1'b1
) (
  input  logic      in_bits [FREE_LIST_DEPTH],
  output pool_idx_t idx
);
  // scan so that the preferred end is assigned last and wins
  always_comb begin
    idx = '0;
    if (HIGH_PRIORITY) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++) if (in_bits[i] == SIGNAL) idx = 5'(i);
    end else begin
      for (int i = FREE_LIST_DEPTH - 1; i >= 0; i--) if (in_bits[i] == SIGNAL) idx = 5'(i);
    end
  end
endmodule

// File: rtl/free_list_allocator_32.sv
// free_list_allocator_32: 32-entry free/busy bitmap granting the lowest free entry each cycle
module free_list_allocator_32
  import mips_core_pkg::*;
#(
  parameter logic [31:0] RESERVED_MASK = 32'h0000_0001,
  parameter int          FREE_LATENCY  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req,
  output logic       alloc_grant,
  output logic [4:0] alloc_idx,
  input  logic       free_valid,
  input  logic [4:0] free_idx,
  input  logic       flush,
  output logic [5:0] free_count,
  output logic       pool_empty,
  output logic       double_free_err
);
  localparam pool_cnt_t RESET_CNT = free_slots(RESERVED_MASK);
  logic [31:0] free_bits, free_bits_n;
  pool_cnt_t   cnt_n;
  logic        pend_valid, pend_valid_n, legal_free, set_valid, err_n;
  pool_idx_t   pend_idx, set_idx, enc_idx;
  logic        enc_in [FREE_LIST_DEPTH];
  // present the bitmap to the encoder as its unpacked input
  always_comb for (int i = 0; i < FREE_LIST_DEPTH; i++) enc_in[i] = free_bits[i];
  priority_encoder_32 #(.HIGH_PRIORITY(1'b0), .SIGNAL(1'b1)) u_enc (
    .in_bits(enc_in),
    .idx    (enc_idx)
  );
  assign alloc_grant = alloc_req & (|free_bits) & ~flush & ~rst;
  assign alloc_idx   = enc_idx;
  // next bitmap/count: grant clears, legal free sets (now or via pending), flush restores
  always_comb begin
    legal_free   = free_valid & ~free_bits[free_idx] & ~RESERVED_MASK[free_idx]
                   & ~(pend_valid & (pend_idx == free_idx));
    set_valid    = (FREE_LATENCY != 0) ? pend_valid : legal_free;
    set_idx      = (FREE_LATENCY != 0) ? pend_idx : free_idx;
    free_bits_n  = free_bits;
    if (alloc_grant) free_bits_n[alloc_idx] = 1'b0;
    if (set_valid) free_bits_n[set_idx] = 1'b1;
    cnt_n        = free_count - {5'd0, alloc_grant} + {5'd0, set_valid};
    pend_valid_n = (FREE_LATENCY != 0) & legal_free;
    err_n        = double_free_err | (free_valid & ~legal_free & ~flush);
    if (flush) begin
      free_bits_n  = ~RESERVED_MASK;
      cnt_n        = RESET_CNT;
      pend_valid_n = 1'b0;
    end
  end
  // pool state with asynchronous restore to the reserved-only configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_bits       <= ~RESERVED_MASK;
      free_count      <= RESET_CNT;
      pool_empty      <= (RESET_CNT == 6'd0);
      double_free_err <= 1'b0;
      pend_valid      <= 1'b0;
      pend_idx        <= '0;
    end else begin
      free_bits       <= free_bits_n;
      free_count      <= cnt_n;
      pool_empty      <= (cnt_n == 6'd0);
      double_free_err <= err_n;
      pend_valid      <= pend_valid_n;
      pend_idx        <= free_idx;
    end
  end
endmodule

// File: tb/tb_free_list_allocator_32.sv
// tb_free_list_allocator_32: scoreboarded checks of grant order, free, flush and reset behaviour
module tb_free_list_allocator_32;
  logic       clk = 1'b0, rst = 1'b0, alloc_req = 1'b0, free_valid = 1'b0, flush = 1'b0;
  logic [4:0] free_idx = 5'd0;
  logic       alloc_grant, pool_empty, double_free_err;
  logic [4:0] alloc_idx;
  logic [5:0] free_count;
  int         n_chk = 0, n_fail = 0;
  logic [31:0] mdl = ~32'h1;
  logic        merr = 1'b0;
  logic [4:0]  exp_q[$];

  free_list_allocator_32 dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_grant(alloc_grant),
    .alloc_idx(alloc_idx), .free_valid(free_valid), .free_idx(free_idx), .flush(flush),
    .free_count(free_count), .pool_empty(pool_empty), .double_free_err(double_free_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] lowest(input logic [31:0] b);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 31; i >= 0; i--) if (b[i]) r = 5'(i);
    return r;
  endfunction

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1; alloc_req = 1'b0; free_valid = 1'b0; flush = 1'b0;
    mdl = ~32'h1; merr = 1'b0; exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cycle(input logic req, input logic fv, input logic [4:0] fi, input logic fl);
    logic       exp_g, legal;
    logic [4:0] gi, e;
    alloc_req = req; free_valid = fv; free_idx = fi; flush = fl;
    exp_g = req && (mdl != 32'd0) && !fl;
    gi    = lowest(mdl);
    legal = !mdl[fi] && (fi != 5'd0);
    if (exp_g) exp_q.push_back(gi);
    @(negedge clk);
    n_chk++;
    if (alloc_grant !== exp_g) begin
      n_fail++; $display("FAIL grant: got %b expected %b", alloc_grant, exp_g);
    end
    if (alloc_grant === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL grant_idx: got %0d with nothing expected", alloc_idx);
      end else begin
        e = exp_q.pop_front();
        if (alloc_idx !== e) begin
          n_fail++; $display("FAIL grant_idx: got %0d expected %0d", alloc_idx, e);
        end
      end
    end
    if (fl) mdl = ~32'h1;
    else begin
      if (exp_g) mdl[gi] = 1'b0;
      if (fv) begin
        if (legal) mdl[fi] = 1'b1;
        else merr = 1'b1;
      end
    end
    @(posedge clk); #1;
    alloc_req = 1'b0; free_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    #1; rst = 1'b1; alloc_req = 1'b1;
    #2;
    n_chk++; if (alloc_grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0", alloc_grant); end
    n_chk++; if (free_count !== 6'd31) begin n_fail++; $display("FAIL reset_count: got %0d expected 31", free_count); end
    n_chk++; if (pool_empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got %b expected 0", pool_empty); end
    n_chk++; if (double_free_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", double_free_err); end
    alloc_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (free_count !== 6'd30) begin n_fail++; $display("FAIL first_alloc_count: got %0d expected 30", free_count); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    repeat (31) cycle(1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (pool_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b expected 1", pool_empty); end
    n_chk++; if (free_count !== 6'd0) begin n_fail++; $display("FAIL b2b_count: got %0d expected 0", free_count); end
    cycle(1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (free_count !== 6'd0) begin n_fail++; $display("FAIL empty_stall_count: got %0d expected 0", free_count); end
  endtask

  task automatic test_free_while_empty;
    cycle(1'b1, 1'b1, 5'd7, 1'b0);
    n_chk++; if (free_count !== 6'($countones(mdl))) begin n_fail++; $display("FAIL empty_free_count: got %0d expected %0d", free_count, $countones(mdl)); end
    n_chk++; if (pool_empty !== 1'b0) begin n_fail++; $display("FAIL empty_free_flag: got %b expected 0", pool_empty); end
    cycle(1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (pool_empty !== 1'b1) begin n_fail++; $display("FAIL regrant_empty: got %b expected 1", pool_empty); end
  endtask

  task automatic test_grant_and_free;
    do_reset();
    repeat (5) cycle(1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (free_count !== 6'd26) begin n_fail++; $display("FAIL five_busy_count: got %0d expected 26", free_count); end
    cycle(1'b1, 1'b1, 5'd3, 1'b0);
    n_chk++; if (free_count !== 6'd26) begin n_fail++; $display("FAIL grant_free_count: got %0d expected 26", free_count); end
    n_chk++; if (double_free_err !== 1'b0) begin n_fail++; $display("FAIL grant_free_err: got %b expected 0", double_free_err); end
    cycle(1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (free_count !== 6'($countones(mdl))) begin n_fail++; $display("FAIL regrant3_count: got %0d expected %0d", free_count, $countones(mdl)); end
  endtask

  task automatic test_double_free;
    do_reset();
    cycle(1'b0, 1'b1, 5'd0, 1'b0);
    n_chk++; if (double_free_err !== merr) begin n_fail++; $display("FAIL reserved_free_err: got %b expected %b", double_free_err, merr); end
    n_chk++; if (free_count !== 6'd31) begin n_fail++; $display("FAIL reserved_free_count: got %0d expected 31", free_count); end
    cycle(1'b0, 1'b1, 5'd9, 1'b0);
    n_chk++; if (free_count !== 6'd31) begin n_fail++; $display("FAIL double_free_count: got %0d expected 31", free_count); end
    repeat (3) cycle(1'b0, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, 1'b0, 5'd0, 1'b1);
    n_chk++; if (double_free_err !== 1'b1) begin n_fail++; $display("FAIL sticky_err: got %b expected 1", double_free_err); end
    cycle(1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (free_count !== 6'd30) begin n_fail++; $display("FAIL post_err_alloc_count: got %0d expected 30", free_count); end
  endtask

  task automatic test_flush;
    do_reset();
    repeat (10) cycle(1'b1, 1'b0, 5'd0, 1'b0);
    n_chk++; if (free_count !== 6'd21) begin n_fail++; $display("FAIL ten_busy_count: got %0d expected 21", free_count); end
    cycle(1'b1, 1'b1, 5'd2, 1'b1);
    n_chk++; if (free_count !== 6'd31) begin n_fail++; $display("FAIL flush_count: got %0d expected 31", free_count); end
    n_chk++; if (double_free_err !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %b expected 0", double_free_err); end
    cycle(1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset_mid;
    do_reset();
    cycle(1'b0, 1'b1, 5'd0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 5'd0, 1'b0);
    alloc_req = 1'b1;
    #2; rst = 1'b1;
    #1;
    n_chk++; if (alloc_grant !== 1'b0) begin n_fail++; $display("FAIL mid_rst_grant: got %b expected 0", alloc_grant); end
    n_chk++; if (free_count !== 6'd31) begin n_fail++; $display("FAIL mid_rst_count: got %0d expected 31", free_count); end
    n_chk++; if (pool_empty !== 1'b0) begin n_fail++; $display("FAIL mid_rst_empty: got %b expected 0", pool_empty); end
    n_chk++; if (double_free_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %b expected 0", double_free_err); end
    alloc_req = 1'b0; mdl = ~32'h1; merr = 1'b0; exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_free_while_empty();
    test_grant_and_free();
    test_double_free();
    test_flush();
    test_reset_mid();
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d grants still expected", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
